// File: rtl/wb_burst_master.sv
// Wishbone classic-cycle burst initiator: word bursts from a valid/ready command port, one beat at a time.
// Define WB_BURST_MASTER_STATS_EN to build the saturating statistics counters; otherwise they read as 0.
module wb_burst_master #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_adr,
    input  logic [DW/8-1:0]   req_sel,
    input  logic [3:0]        req_len,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [DW-1:0]     wdat,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_dat,
    output logic [1:0]        rsp_status,
    output logic              rsp_last,
    output logic [AW-1:0]     m_wb_adr_o,
    output logic [DW/8-1:0]   m_wb_sel_o,
    output logic              m_wb_we_o,
    output logic [DW-1:0]     m_wb_dat_o,
    output logic              m_wb_cyc_o,
    output logic              m_wb_stb_o,
    input  logic [DW-1:0]     m_wb_dat_i,
    input  logic              m_wb_ack_i,
    input  logic              m_wb_err_i,
    input  logic              m_wb_rty_i,
    output logic [31:0]       stat_beats,
    output logic [15:0]       stat_retries,
    output logic [15:0]       stat_errs
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WDATA,
        S_STROBE,
        S_GAP
    } state_t;

    localparam int SW = DW / 8;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    state_t          state_q, state_d;
    logic            req_ready_q, req_ready_d;
    logic            wdat_ready_q, wdat_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic [1:0]      rsp_status_q, rsp_status_d;
    logic            rsp_last_q, rsp_last_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            we_q, we_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      beat_cnt_q, beat_cnt_d;
    logic [31:0]     retry_cnt_q, retry_cnt_d;
    logic [31:0]     wait_cnt_q, wait_cnt_d;

    logic            finish_cmd;
    logic [1:0]      finish_status;

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        wdat_ready_d  = wdat_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_dat_d     = '0;
        rsp_status_d  = ST_OK;
        rsp_last_d    = 1'b0;
        adr_d         = adr_q;
        sel_d         = sel_q;
        we_d          = we_q;
        dat_d         = dat_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        retry_cnt_d   = retry_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        finish_cmd    = 1'b0;
        finish_status = ST_OK;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    adr_d        = req_adr;
                    sel_d        = req_sel;
                    len_d        = req_len;
                    beat_cnt_d   = '0;
                    retry_cnt_d  = '0;
                    wait_cnt_d   = '0;
                    req_ready_d  = 1'b0;
                    if (req_we) begin
                        state_d      = S_WDATA;
                        wdat_ready_d = 1'b1;
                    end else begin
                        state_d = S_STROBE;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                    end
                end
            end

            S_WDATA: begin
                if (wdat_valid) begin
                    wdat_ready_d = 1'b0;
                    dat_d        = wdat;
                    cyc_d        = 1'b1;
                    stb_d        = 1'b1;
                    state_d      = S_STROBE;
                end
            end

            // err beats ack beats rty when a slave asserts several at once.
            S_STROBE: begin
                if (m_wb_err_i) begin
                    finish_cmd    = 1'b1;
                    finish_status = ST_ERR;
                end else if (m_wb_ack_i) begin
                    rsp_valid_d  = 1'b1;
                    rsp_dat_d    = we_q ? '0 : m_wb_dat_i;
                    beat_cnt_d   = beat_cnt_q + 4'd1;
                    adr_d        = adr_q + AW'(4);
                    retry_cnt_d  = '0;
                    wait_cnt_d   = '0;
                    if (beat_cnt_q == len_q) begin
                        finish_cmd    = 1'b1;
                        finish_status = ST_OK;
                    end else begin
                        stb_d = 1'b0;
                        if (we_q) begin
                            state_d      = S_WDATA;
                            wdat_ready_d = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end else if (m_wb_rty_i) begin
                    if (retry_cnt_q < 32'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + 32'd1;
                        wait_cnt_d  = '0;
                        stb_d       = 1'b0;
                        state_d     = S_GAP;
                    end else begin
                        finish_cmd    = 1'b1;
                        finish_status = ST_RTY;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                    if ((TIMEOUT_CYC != 0) && (wait_cnt_q == 32'(TIMEOUT_CYC - 1))) begin
                        finish_cmd    = 1'b1;
                        finish_status = ST_TMO;
                    end
                end
            end

            S_GAP: begin
                stb_d   = 1'b1;
                state_d = S_STROBE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every way out of a command releases the bus on the same edge as the last response.
        if (finish_cmd) begin
            rsp_valid_d  = 1'b1;
            rsp_last_d   = 1'b1;
            rsp_status_d = finish_status;
            cyc_d        = 1'b0;
            stb_d        = 1'b0;
            wdat_ready_d = 1'b0;
            req_ready_d  = 1'b1;
            state_d      = S_IDLE;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            wdat_ready_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
            rsp_last_q   <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            dat_q        <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            retry_cnt_q  <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            wdat_ready_q <= wdat_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            rsp_last_q   <= rsp_last_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            dat_q        <= dat_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign wdat_ready = wdat_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;
    assign rsp_last   = rsp_last_q;
    assign m_wb_adr_o = adr_q;
    assign m_wb_sel_o = sel_q;
    assign m_wb_we_o  = we_q;
    assign m_wb_dat_o = dat_q;
    assign m_wb_cyc_o = cyc_q;
    assign m_wb_stb_o = stb_q;

`ifdef WB_BURST_MASTER_STATS_EN
    logic        beat_evt, retry_evt, abort_evt;
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [15:0] stat_retries_q, stat_retries_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    // Events mirror the termination priority used by the main state machine.
    always_comb begin
        beat_evt       = (state_q == S_STROBE) && !m_wb_err_i && m_wb_ack_i;
        retry_evt      = (state_q == S_STROBE) && !m_wb_err_i && !m_wb_ack_i && m_wb_rty_i;
        abort_evt      = finish_cmd && (finish_status != ST_OK);
        stat_beats_d   = stat_beats_q;
        stat_retries_d = stat_retries_q;
        stat_errs_d    = stat_errs_q;
        if (beat_evt && (stat_beats_q != '1)) begin
            stat_beats_d = stat_beats_q + 32'd1;
        end
        if (retry_evt && (stat_retries_q != '1)) begin
            stat_retries_d = stat_retries_q + 16'd1;
        end
        if (abort_evt && (stat_errs_q != '1)) begin
            stat_errs_d = stat_errs_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stat_beats_q   <= '0;
            stat_retries_q <= '0;
            stat_errs_q    <= '0;
        end else begin
            stat_beats_q   <= stat_beats_d;
            stat_retries_q <= stat_retries_d;
            stat_errs_q    <= stat_errs_d;
        end
    end

    assign stat_beats   = stat_beats_q;
    assign stat_retries = stat_retries_q;
    assign stat_errs    = stat_errs_q;
`else
    assign stat_beats   = '0;
    assign stat_retries = '0;
    assign stat_errs    = '0;
`endif

endmodule
